control_sequencer: RTL

Registered, handshaked successor to the combinational RV32I control decoder. It accepts full 32-bit instructions from fetch with valid/ready and decodes them into a control word held in a pipeline register. Memory instructions are sequenced through a multi-cycle FSM that waits for a memory acknowledge, bounded by a timeout. The block sits between fetch and execute and adds half/unsigned loads and stores, SLT/SLTU distinction, flush and illegal-instruction reporting.

---
 rtl/control_pkg.sv | 64 ++++++
 rtl/control_sequencer_if.sv | 59 +++++
 rtl/inst_decoder.sv | 103 ++++++++++
 rtl/control_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared encodings, opcodes and control word for control_sequencer
package control_pkg;

   typedef enum logic [3:0] {
      FOP_ADD = 4'd0,
      FOP_SUB = 4'd1,
      FOP_SLL = 4'd2,
      FOP_SRL = 4'd3,
      FOP_SRA = 4'd4,
      FOP_AND = 4'd5,
      FOP_OR  = 4'd6,
      FOP_XOR = 4'd7,
      FOP_IMM = 4'd8
   } fop_t;

   typedef enum logic [2:0] {
      NONE = 3'd0,
      BEQ  = 3'd1,
      BNE  = 3'd2,
      BLT  = 3'd3,
      BGE  = 3'd4,
      BLTU = 3'd5,
      BGEU = 3'd6,
      JMP  = 3'd7
   } b_t;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } mem_size_t;

   localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef struct packed {
      logic      legal;
      fop_t      alu_op;
      b_t        branch_type;
      logic      reg_write_en;
      logic      alu_mux_en;
      logic      mem_to_reg;
      logic      pc_add_write_value;
      logic      read_next_pc;
      logic      slt;
      logic      slt_unsigned;
      logic      mem_read;
      logic      mem_write;
      mem_size_t mem_size;
      logic      mem_unsigned;
   } ctrl_word_t;

   function automatic logic is_mem_op(input ctrl_word_t w);
      return w.mem_read || w.mem_write;
   endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - fetch/execute/memory bundle; CTRL_PERF_CNT_EN adds perf counters
interface control_sequencer_if;
   import control_pkg::*;

   logic        inst_valid;
   logic [31:0] inst;
   logic        inst_ready;
   logic        flush;
   logic        ex_ready;
   logic        ctrl_valid;
   fop_t        alu_op;
   b_t          branch_type;
   logic        reg_write_en;
   logic        alu_mux_en;
   logic        mem_to_reg;
   logic        pc_add_write_value;
   logic        read_next_pc;
   logic        slt;
   logic        slt_unsigned;
   logic        mem_read;
   logic        mem_write;
   mem_size_t   mem_size;
   logic        mem_unsigned;
   logic        mem_ack;
   logic        mem_err;
   logic        illegal_inst;
`ifdef CTRL_PERF_CNT_EN
   logic [31:0] retired_cnt;
   logic [31:0] stall_cnt;

   modport slave (
      input  inst_valid, inst, flush, ex_ready, mem_ack,
      output inst_ready, ctrl_valid, alu_op, branch_type, reg_write_en, alu_mux_en,
             mem_to_reg, pc_add_write_value, read_next_pc, slt, slt_unsigned,
             mem_read, mem_write, mem_size, mem_unsigned, mem_err, illegal_inst,
             retired_cnt, stall_cnt
   );
   modport master (
      output inst_valid, inst, flush, ex_ready, mem_ack,
      input  inst_ready, ctrl_valid, alu_op, branch_type, reg_write_en, alu_mux_en,
             mem_to_reg, pc_add_write_value, read_next_pc, slt, slt_unsigned,
             mem_read, mem_write, mem_size, mem_unsigned, mem_err, illegal_inst,
             retired_cnt, stall_cnt
   );
`else
   modport slave (
      input  inst_valid, inst, flush, ex_ready, mem_ack,
      output inst_ready, ctrl_valid, alu_op, branch_type, reg_write_en, alu_mux_en,
             mem_to_reg, pc_add_write_value, read_next_pc, slt, slt_unsigned,
             mem_read, mem_write, mem_size, mem_unsigned, mem_err, illegal_inst
   );
   modport master (
      output inst_valid, inst, flush, ex_ready, mem_ack,
      input  inst_ready, ctrl_valid, alu_op, branch_type, reg_write_en, alu_mux_en,
             mem_to_reg, pc_add_write_value, read_next_pc, slt, slt_unsigned,
             mem_read, mem_write, mem_size, mem_unsigned, mem_err, illegal_inst
   );
`endif
endinterface

// File: rtl/inst_decoder.sv
// rtl/inst_decoder.sv - combinational RV32I decode of a raw instruction into a control word
module inst_decoder
   import control_pkg::*;
(
   input  logic [31:0] inst_i,
   output ctrl_word_t  word_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       f7b5;
   logic       unused_bits;

   assign opcode      = inst_i[6:0];
   assign funct3      = inst_i[14:12];
   assign f7b5        = inst_i[30];
   assign unused_bits = ^{inst_i[31], inst_i[29:15], inst_i[11:7]};

   always_comb begin
      word_o = '0;
      case (opcode)
         OPC_RTYPE, OPC_ITYPE: begin
            word_o.legal        = 1'b1;
            word_o.reg_write_en = 1'b1;
            word_o.alu_mux_en   = (opcode == OPC_ITYPE);
            case (funct3)
               // addi has no sub form, so funct7[5] only matters for the R-type add
               3'b000:  word_o.alu_op = (opcode == OPC_RTYPE && f7b5) ? FOP_SUB : FOP_ADD;
               3'b001:  word_o.alu_op = FOP_SLL;
               3'b010: begin
                  word_o.alu_op = FOP_SUB;
                  word_o.slt    = 1'b1;
               end
               3'b011: begin
                  word_o.alu_op       = FOP_SUB;
                  word_o.slt          = 1'b1;
                  word_o.slt_unsigned = 1'b1;
               end
               3'b100:  word_o.alu_op = FOP_XOR;
               3'b101:  word_o.alu_op = f7b5 ? FOP_SRA : FOP_SRL;
               3'b110:  word_o.alu_op = FOP_OR;
               default: word_o.alu_op = FOP_AND;
            endcase
         end
         OPC_LOAD: begin
            word_o.legal        = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            word_o.reg_write_en = 1'b1;
            word_o.alu_mux_en   = 1'b1;
            word_o.mem_to_reg   = 1'b1;
            word_o.mem_read     = 1'b1;
            word_o.mem_size     = mem_size_t'(funct3[1:0]);
            word_o.mem_unsigned = funct3[2];
         end
         OPC_STORE: begin
            word_o.legal      = funct3 inside {3'b000, 3'b001, 3'b010};
            word_o.alu_mux_en = 1'b1;
            word_o.mem_write  = 1'b1;
            word_o.mem_size   = mem_size_t'(funct3[1:0]);
         end
         OPC_LUI: begin
            word_o.legal        = 1'b1;
            word_o.reg_write_en = 1'b1;
            word_o.alu_mux_en   = 1'b1;
            word_o.alu_op       = FOP_IMM;
         end
         OPC_AUIPC: begin
            word_o.legal              = 1'b1;
            word_o.reg_write_en       = 1'b1;
            word_o.alu_mux_en         = 1'b1;
            word_o.pc_add_write_value = 1'b1;
         end
         OPC_BRANCH: begin
            word_o.alu_op = FOP_SUB;
            word_o.legal  = 1'b1;
            case (funct3)
               3'b000:  word_o.branch_type = BEQ;
               3'b001:  word_o.branch_type = BNE;
               3'b100:  word_o.branch_type = BLT;
               3'b101:  word_o.branch_type = BGE;
               3'b110:  word_o.branch_type = BLTU;
               3'b111:  word_o.branch_type = BGEU;
               default: word_o.legal       = 1'b0;
            endcase
         end
         OPC_JAL: begin
            word_o.legal        = 1'b1;
            word_o.reg_write_en = 1'b1;
            word_o.branch_type  = JMP;
            word_o.read_next_pc = 1'b1;
         end
         OPC_JALR: begin
            word_o.legal              = (funct3 == 3'b000);
            word_o.reg_write_en       = 1'b1;
            word_o.alu_mux_en         = 1'b1;
            word_o.branch_type        = JMP;
            word_o.read_next_pc       = 1'b1;
            word_o.pc_add_write_value = 1'b1;
         end
         default: word_o = '0;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - handshaked decode register with memory-wait FSM and timeout
// CTRL_PERF_CNT_EN adds retired/stall counters to the bus.
module control_sequencer
   import control_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                nRst,
   control_sequencer_if.slave  bus
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, MEM} state_t;

   state_t           state_q, state_d;
   ctrl_word_t       word_q, word_d, dec_word;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ctrl_valid_q, ctrl_valid_d;
   logic             mem_read_q, mem_read_d;
   logic             mem_write_q, mem_write_d;
   logic             mem_err_q, mem_err_d;
   logic             illegal_q, illegal_d;
   logic             inst_ready;
   logic             accept;
   logic             unused_word;

   inst_decoder u_decoder (
      .inst_i (bus.inst),
      .word_o (dec_word)
   );

   assign inst_ready = !bus.flush && ((state_q == IDLE) || (state_q == ISSUE && bus.ex_ready));
   assign accept     = inst_ready && bus.inst_valid;

   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      cnt_d     = cnt_q;
      mem_err_d = 1'b0;
      illegal_d = 1'b0;
      if (bus.flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE, ISSUE: begin
               if (state_q == ISSUE && bus.ex_ready) state_d = IDLE;
               if (accept) begin
                  word_d = dec_word;
                  cnt_d  = '0;
                  if (!dec_word.legal) begin
                     illegal_d = 1'b1;
                     state_d   = IDLE;
                  end else if (is_mem_op(dec_word)) begin
                     state_d = MEM;
                  end else begin
                     state_d = ISSUE;
                  end
               end
            end
            MEM: begin
               // an ack arriving on the last allowed cycle still completes the access
               if (bus.mem_ack) begin
                  state_d = ISSUE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                  state_d   = IDLE;
                  mem_err_d = 1'b1;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
      ctrl_valid_d = (state_d == ISSUE);
      mem_read_d   = (state_d == MEM) && word_d.mem_read;
      mem_write_d  = (state_d == MEM) && word_d.mem_write;
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state_q      <= IDLE;
         word_q       <= '0;
         cnt_q        <= '0;
         ctrl_valid_q <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_err_q    <= 1'b0;
         illegal_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         cnt_q        <= cnt_d;
         ctrl_valid_q <= ctrl_valid_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_err_q    <= mem_err_d;
         illegal_q    <= illegal_d;
      end
   end

   assign bus.inst_ready         = inst_ready;
   assign bus.ctrl_valid         = ctrl_valid_q;
   assign bus.alu_op             = word_q.alu_op;
   assign bus.branch_type        = word_q.branch_type;
   assign bus.reg_write_en       = word_q.reg_write_en;
   assign bus.alu_mux_en         = word_q.alu_mux_en;
   assign bus.mem_to_reg         = word_q.mem_to_reg;
   assign bus.pc_add_write_value = word_q.pc_add_write_value;
   assign bus.read_next_pc       = word_q.read_next_pc;
   assign bus.slt                = word_q.slt;
   assign bus.slt_unsigned       = word_q.slt_unsigned;
   assign bus.mem_read           = mem_read_q;
   assign bus.mem_write          = mem_write_q;
   assign bus.mem_size           = word_q.mem_size;
   assign bus.mem_unsigned       = word_q.mem_unsigned;
   assign bus.mem_err            = mem_err_q;
   assign bus.illegal_inst       = illegal_q;
   assign unused_word            = word_q.legal ^ word_q.mem_read ^ word_q.mem_write;

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] retired_q;
   logic [31:0] stall_q;
   logic        retire;
   logic        stall;

   assign retire = ctrl_valid_q && bus.ex_ready;
   assign stall  = (state_q == MEM) || (state_q == ISSUE && !bus.ex_ready);

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         retired_q <= '0;
         stall_q   <= '0;
      end else begin
         retired_q <= retired_q + {31'd0, retire};
         stall_q   <= stall_q + {31'd0, stall};
      end
   end

   assign bus.retired_cnt = retired_q;
   assign bus.stall_cnt   = stall_q;
`else
   // counters are compiled out in the default build
`endif

endmodule
